johnson_phase_decoder: RTL and testbench

Downstream consumer of the 4-bit johnson_counter output. It samples Count_in every clock and decodes the Johnson code into a binary phase index and a one-hot phase vector. It also checks that each new code is a legal hold or single step of the sequence, flags corruption, and counts full revolutions. It sits between johnson_counter and any logic that needs phase-select or timing strobes.

---
 rtl/johnson_phase_decoder.sv | 138 +++++++++++++
 tb/tb_johnson_phase_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Johnson code decoder: binary phase, one-hot phase, sequence checking
// and revolution counting for a WIDTH-bit Johnson counter output.
module johnson_phase_decoder #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH),
  parameter int CW    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     Count_in,
  input  logic                 Error_clear,
  output logic [PW-1:0]        Phase_out,
  output logic [2*WIDTH-1:0]   Onehot_out,
  output logic                 Valid_out,
  output logic                 Seq_error,
  output logic                 Error_sticky,
  output logic                 Wrap_pulse,
  output logic [CW-1:0]        Wrap_count
);

  localparam int NS = 2*WIDTH;
  localparam logic [0:0] ACQUIRE = 1'b0;
  localparam logic [0:0] LOCKED  = 1'b1;
  localparam logic [PW-1:0] LAST = PW'(NS-1);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [NS-1:0] onehot_q, onehot_d;
  logic          err_q, err_d;
  logic          sticky_q, sticky_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic          code_ok;
  logic [PW-1:0] code_ph;
  logic [PW-1:0] succ;
  logic          is_hold;
  logic          is_step;
  logic [NS-1:0] oh_new;

  // Phase k<=N: low k bits set; phase N+k: high N-k bits set.
  function automatic logic [WIDTH-1:0] pattern(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) return ~(ones << k);
    return ones << (k - WIDTH);
  endfunction

  always_comb begin
    code_ok = 1'b0;
    code_ph = '0;
    for (int k = 0; k < NS; k++) begin
      if (Count_in == pattern(k)) begin
        code_ok = 1'b1;
        code_ph = PW'(k);
      end
    end
  end

  always_comb begin
    succ    = (phase_q == LAST) ? '0
                                : phase_q + PW'(1);
    is_hold = code_ok && (code_ph == phase_q);
    is_step = code_ok && (code_ph == succ);
    oh_new  = NS'(1) << code_ph;
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    onehot_d = onehot_q;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    wcnt_d   = wcnt_q;
    if (state_q == ACQUIRE) begin
      if (code_ok) begin
        state_d  = LOCKED;
        phase_d  = code_ph;
        onehot_d = oh_new;
      end else begin
        err_d    = 1'b1;
        onehot_d = '0;
      end
    end else begin
      unique case (1'b1)
        is_hold: begin
          phase_d = phase_q;
        end
        is_step: begin
          phase_d  = code_ph;
          onehot_d = oh_new;
          if (phase_q == LAST) begin
            wrap_d = 1'b1;
            wcnt_d = wcnt_q + CW'(1);
          end
        end
        default: begin
          err_d    = 1'b1;
          state_d  = ACQUIRE;
          onehot_d = '0;
        end
      endcase
    end
    // A new error outranks a simultaneous clear.
    if (err_d)            sticky_d = 1'b1;
    else if (Error_clear) sticky_d = 1'b0;
    else                  sticky_d = sticky_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ACQUIRE;
      phase_q  <= '0;
      onehot_q <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      wrap_q   <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      onehot_q <= onehot_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      wrap_q   <= wrap_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign Phase_out    = phase_q;
  assign Onehot_out   = onehot_q;
  assign Valid_out    = (state_q == LOCKED);
  assign Seq_error    = err_q;
  assign Error_sticky = sticky_q;
  assign Wrap_pulse   = wrap_q;
  assign Wrap_count   = wcnt_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed plan plus a random walk
// over the Johnson sequence, checked against a table-driven model.
module tb_johnson_phase_decoder;

  localparam int W  = 4;
  localparam int PW = 3;
  localparam int CW = 8;

  logic          Clock;
  logic          Reset;
  logic [W-1:0]  Count_in;
  logic          Error_clear;
  logic [PW-1:0] Phase_out;
  logic [2*W-1:0] Onehot_out;
  logic          Valid_out;
  logic          Seq_error;
  logic          Error_sticky;
  logic          Wrap_pulse;
  logic [CW-1:0] Wrap_count;

  johnson_phase_decoder #(
    .WIDTH(W), .PW(PW), .CW(CW)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Count_in(Count_in),
    .Error_clear(Error_clear),
    .Phase_out(Phase_out),
    .Onehot_out(Onehot_out),
    .Valid_out(Valid_out),
    .Seq_error(Seq_error),
    .Error_sticky(Error_sticky),
    .Wrap_pulse(Wrap_pulse),
    .Wrap_count(Wrap_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  int seq [8] = '{0, 1, 3, 7, 15, 14, 12, 8};

  bit m_lock;
  int m_ph;
  int m_wraps;
  bit m_sticky;
  bit m_err;
  bit m_wrap;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int code);
    for (int i = 0; i < 8; i++)
      if (seq[i] == code) return i;
    return -1;
  endfunction

  task automatic step(input int code, input bit clr, input bit rst);
    int i;
    logic [31:0] c;
    c = code;
    Reset       = rst;
    Count_in    = c[W-1:0];
    Error_clear = clr;
    @(posedge Clock);
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_lock   = 1'b0;
      m_ph     = 0;
      m_sticky = 1'b0;
      m_wraps  = 0;
    end else begin
      i = idx_of(code);
      if (!m_lock) begin
        if (i >= 0) begin
          m_lock = 1'b1;
          m_ph   = i;
        end else m_err = 1'b1;
      end else if (i == m_ph) begin
        m_lock = 1'b1;
      end else if (i >= 0 && i == (m_ph + 1) % 8) begin
        if (i == 0) begin
          m_wrap  = 1'b1;
          m_wraps = (m_wraps + 1) % 256;
        end
        m_ph = i;
      end else begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end
      if (m_err)    m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
    end
    #1;
    check("phase", 32'(Phase_out), m_ph);
    check("onehot", 32'(Onehot_out),
          m_lock ? (32'd1 << m_ph) : 32'd0);
    check("valid", 32'(Valid_out), 32'(m_lock));
    check("seq_err", 32'(Seq_error), 32'(m_err));
    check("sticky", 32'(Error_sticky), 32'(m_sticky));
    check("wrap_p", 32'(Wrap_pulse), 32'(m_wrap));
    check("wrap_c", 32'(Wrap_count), m_wraps);
  endtask

  initial begin
    int ci;
    int r;
    Reset       = 1'b1;
    Count_in    = '0;
    Error_clear = 1'b0;

    repeat (3) step(0, 0, 1);
    check("rst_valid", 32'(Valid_out), 0);
    check("rst_oh", 32'(Onehot_out), 0);

    for (int i = 0; i < 20; i++) step(seq[i % 8], 0, 0);
    check("two_wraps", 32'(Wrap_count), 2);

    repeat (5) step(7, 0, 0);
    check("hold_ph", 32'(Phase_out), 3);
    check("hold_oh", 32'(Onehot_out), 32'h08);

    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(3, 0, 0);
    step(15, 0, 0);
    check("skip_err", 32'(Seq_error), 1);
    check("skip_ph", 32'(Phase_out), 2);
    step(14, 0, 0);
    check("relock_ph", 32'(Phase_out), 5);
    check("relock_v", 32'(Valid_out), 1);

    step(0, 0, 1);
    step(5, 0, 0);
    step(0, 0, 0);
    step(5, 0, 0);
    check("ill_lock", 32'(Valid_out), 0);
    step(0, 1, 0);
    check("clr_ok", 32'(Error_sticky), 0);
    step(5, 1, 0);
    check("clr_lose", 32'(Error_sticky), 1);

    step(0, 0, 1);
    for (int rv = 0; rv < 256; rv++)
      for (int p = 0; p < 8; p++) step(seq[p], 0, 0);
    step(0, 0, 0);
    check("roll_cnt", 32'(Wrap_count), 0);
    check("roll_p", 32'(Wrap_pulse), 1);
    for (int p = 1; p <= 5; p++) step(seq[p], 0, 0);
    step(12, 0, 1);
    check("mid_rst_ph", 32'(Phase_out), 0);
    check("mid_rst_v", 32'(Valid_out), 0);

    ci = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        step(seq[ci], ($urandom_range(0, 9) == 0), 0);
      end else if (r < 85) begin
        ci = (ci + 1) % 8;
        step(seq[ci], ($urandom_range(0, 9) == 0), 0);
      end else if (r < 90) begin
        ci = (ci + 7) % 8;
        step(seq[ci], ($urandom_range(0, 9) == 0), 0);
      end else if (r < 99) begin
        r = $urandom_range(0, 15);
        if (idx_of(r) >= 0) ci = idx_of(r);
        step(r, ($urandom_range(0, 9) == 0), 0);
      end else begin
        step(seq[ci], 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
